uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line input and received-byte outputs of the UART receiver.
//
// Handshake: there is no ready path. done is a one-cycle strobe that marks
// data_out as holding a newly received byte, and data_out stays stable until
// the next done. frame_err is a one-cycle strobe that reports a bad stop bit.
// done and frame_err are never high in the same cycle. state_dbg mirrors the
// receiver FSM state for observation only.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 done;
    logic                 busy;
    logic                 frame_err;
    rx_state_e            state_dbg;

    // Line driver / byte consumer side.
    modport master (
        output rx,
        input  data_out, done, busy, frame_err, state_dbg
    );

    // Receiver side.
    modport slave (
        input  rx,
        output data_out, done, busy, frame_err, state_dbg
    );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Flops reset to 1
// so that a line in reset never looks like a start bit.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Shift the raw line through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. A falling edge on the synchronized line starts a frame.
// The start bit is re-checked at its middle, and each data bit and the stop
// bit are sampled once per bit period after that. The FSM returns to IDLE at
// mid-stop, which allows a following start edge to arrive right at the
// nominal end of the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int COUNT_CYCLES = CLK_FREQ / BAUD
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int CW = $clog2(COUNT_CYCLES) + 1;

    // The counter is loaded with N-1 and expires at 0, so a load lasts N clocks.
    localparam logic [CW-1:0] HALF_LOAD = CW'(COUNT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(COUNT_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 cnt_done;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 ferr_q;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx),
        .q_o (rx_s)
    );

    assign cnt_done = (cnt_q == '0);
    assign cnt_d    = cnt_q - CW'(1);

    // Receiver FSM. The line is only looked at on counter expiry outside
    // IDLE and WAIT_HIGH. All outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= HALF_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_d;
                    end else if (!rx_s) begin
                        state_q   <= DATA;
                        cnt_q     <= FULL_LOAD;
                        bit_idx_q <= '0;
                    end else begin
                        // Line went high again: treat it as a glitch.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                DATA: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_d;
                    end else begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_d;
                    end else if (rx_s) begin
                        data_q  <= shift_q;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // Bad stop bit: keep the old byte and wait out the low line.
                        ferr_q  <= 1'b1;
                        state_q <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = ferr_q;
    assign bus.state_dbg = state_q;

endmodule
